// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, jr/jalr hazard
// classes and the default mult/div timeout.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_JR_STALL = 2'b10,
        ST_MD_WAIT  = 2'b11
    } hz_state_e;

    localparam logic [1:0] JR_NONE = 2'b00;
    localparam logic [1:0] JR_ALU  = 2'b01;
    localparam logic [1:0] JR_LOAD = 2'b10;

    localparam int MD_TIMEOUT_DEF = 63;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and jr/jalr bubbles, mult/div wait
// with timeout, branch flush and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rf_wa_ex,
    input  logic             MemRead_ex,
    input  logic [1:0]       JRegDst,
    input  logic             Branch_taken,
    input  logic             MulDiv_start,
    input  logic             MulDiv_done,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_hold,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_W = (MD_TIMEOUT < 1) ? 1 : $clog2(MD_TIMEOUT + 1);

    hz_state_e       state, state_nxt;
    logic            jr_cnt, jr_cnt_nxt;
    logic [MD_W-1:0] md_cnt, md_cnt_nxt;
    logic            set_timeout;
    logic            load_use;

    assign load_use = MemRead_ex && (rf_wa_ex != 5'd0) &&
                      ((rf_wa_ex == rs) || (rf_wa_ex == rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            jr_cnt     <= 1'b0;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            state  <= state_nxt;
            jr_cnt <= jr_cnt_nxt;
            md_cnt <= md_cnt_nxt;
            if (set_timeout) begin
                md_timeout <= 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        jr_cnt_nxt  = jr_cnt;
        md_cnt_nxt  = md_cnt;
        set_timeout = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_hold  = 1'b0;

        // Outputs must read as no-hazard for as long as reset is held.
        if (rst_n) begin
            unique case (state)
                ST_RUN: begin
                    if (MulDiv_start) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        EXMEM_hold = 1'b1;
                        md_cnt_nxt = '0;
                        state_nxt  = ST_MD_WAIT;
                    end else if (load_use) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEX_flush = 1'b1;
                        state_nxt  = ST_LU_STALL;
                    end else if (JRegDst != JR_NONE) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEX_flush = 1'b1;
                        jr_cnt_nxt = (JRegDst == JR_LOAD);
                        state_nxt  = ST_JR_STALL;
                    end else if (Branch_taken) begin
                        IFID_flush = 1'b1;
                    end
                end

                ST_LU_STALL: begin
                    state_nxt = ST_RUN;
                end

                ST_JR_STALL: begin
                    if (jr_cnt != 1'b0) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEX_flush = 1'b1;
                        jr_cnt_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end

                ST_MD_WAIT: begin
                    if (MulDiv_done) begin
                        state_nxt = ST_RUN;
                    end else begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        EXMEM_hold = 1'b1;
                        if (md_cnt == MD_W'(MD_TIMEOUT)) begin
                            set_timeout = 1'b1;
                            state_nxt   = ST_RUN;
                        end else begin
                            md_cnt_nxt = md_cnt + MD_W'(1);
                        end
                    end
                end

                default: state_nxt = ST_RUN;
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!PCWrite),
        .count (stall_cnt)
    );

endmodule
